// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud/frame arithmetic helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  // Clock cycles per complete frame (start + 8 data + optional parity + stop bits).
  function automatic int unsigned frame_len(input int unsigned div,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return div * (1 + 8 + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Register-based synchronous FIFO with first-word fall-through read data.
module uart_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  lvl_q;
  logic              push_ok;
  logic              pop_ok;

  // Overflow/underflow requests are dropped so stored data is never corrupted.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      lvl_q <= lvl_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign level   = lvl_q;

endmodule

// File: rtl/uart_tx_reporter.sv
// UART transmitter: queues status bytes in a FIFO and serialises them LSB first on uart_txd.
module uart_tx_reporter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH) + 1;

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              line_c;
  logic              pop_c;
  logic              push_c;
  logic              bit_end_c;
  logic [7:0]        fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  level_nxt_c;

  assign push_c      = tx_valid & tx_ready & ~fifo_full;
  assign bit_end_c   = (baud_q == CNT_W'(BAUD_DIV - 1));
  assign level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);

  uart_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wr_data (tx_data),
    .pop     (pop_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // FSM, baud/bit counters, shift register and parity accumulator state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // Next-state, line level and FIFO pop decisions.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_c  = 1'b1;
    pop_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_rd_data;
          par_d   = 1'b0;
          state_d = START;
        end
      end

      START: begin
        line_c = 1'b0;
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      DATA: begin
        line_c = shift_q[0];
        if (bit_end_c) begin
          baud_d  = '0;
          par_d   = par_q ^ shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      PARITY: begin
        line_c = par_q ^ 1'(PARITY_ODD);
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      STOP: begin
        line_c = 1'b1;
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit when more bytes are queued.
            if (!fifo_empty) begin
              pop_c   = 1'b1;
              shift_d = fifo_rd_data;
              par_d   = 1'b0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; ready looks ahead at the post-edge FIFO level so it never lags full.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      uart_txd <= line_c;
      tx_busy  <= (state_q != IDLE) || !fifo_empty;
      tx_ready <= (level_nxt_c != LVL_W'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_uart_tx_reporter.sv
// Directed bench for uart_tx_reporter at BAUD_DIV=10: timing, parity, stop bits, FIFO, reset.
module tb_uart_tx_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       tx_busy;
  logic [3:0] fifo_level;

  logic [7:0] p_data = 8'h00;
  logic       pe_valid = 1'b0, po_valid = 1'b0;
  logic       pe_ready, pe_txd, pe_busy;
  logic       po_ready, po_txd, po_busy;
  logic [3:0] pe_level, po_level;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_reporter #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .FIFO_DEPTH(8),
                     .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_level(fifo_level));

  uart_tx_reporter #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .FIFO_DEPTH(8),
                     .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_pe (
    .clk(clk), .rst(rst), .tx_data(p_data), .tx_valid(pe_valid), .tx_ready(pe_ready),
    .uart_txd(pe_txd), .tx_busy(pe_busy), .fifo_level(pe_level));

  uart_tx_reporter #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .FIFO_DEPTH(8),
                     .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_po (
    .clk(clk), .rst(rst), .tx_data(p_data), .tx_valid(po_valid), .tx_ready(po_ready),
    .uart_txd(po_txd), .tx_busy(po_busy), .fifo_level(po_level));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy !== 1'b0 && n < 5000) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(tx_busy), 32'd0);
    repeat (5) step();
  endtask

  // Line receiver: finds the start bit, then samples mid-bit.
  task automatic rx_byte(output logic [7:0] d, output int start_cyc);
    int n = 0;
    d = 8'h00;
    while (uart_txd !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    check("rx_start_timeout", 32'(n < 3000), 32'd1);
    start_cyc = cyc;
    repeat (5) step();
    check("rx_start_mid", 32'(uart_txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) step();
      d[i] = uart_txd;
    end
    repeat (10) step();
    check("rx_stop_mid", 32'(uart_txd), 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] d;
    logic       exp_txd, exp_pe, exp_po;
    logic       acc, saw_full, quiet;
    int         s1, s2, s3, n;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_ready", 32'(tx_ready), 32'd1);
    check("post_rst_pe_ready", 32'(pe_ready), 32'd1);
    check("post_rst_po_ready", 32'(po_ready), 32'd1);

    // Single byte 0x55, cycle-exact waveform
    b = 8'h55;
    tx_data = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check("t1_level_push", 32'(fifo_level), 32'd1);
    for (int c = 1; c <= 102; c++) begin
      step();
      if (c == 1) check("t1_level_pop", 32'(fifo_level), 32'd0);
      exp_txd = (c >= 2 && c <= 11) ? 1'b0 : (c >= 12 && c <= 91) ? b[(c - 12) / 10] : 1'b1;
      check($sformatf("t1_txd@%0d", c), 32'(uart_txd), 32'(exp_txd));
      check($sformatf("t1_busy@%0d", c), 32'(tx_busy), (c <= 101) ? 32'd1 : 32'd0);
    end
    wait_idle();

    // Burst A5,3C,FF back-to-back: no idle gap, level peaks at 2
    fork
      begin
        tx_data = 8'hA5; tx_valid = 1'b1; step();
        check("burst_level0", 32'(fifo_level), 32'd1);
        tx_data = 8'h3C; step();
        check("burst_level1", 32'(fifo_level), 32'd1);
        tx_data = 8'hFF; step();
        check("burst_level2", 32'(fifo_level), 32'd2);
        tx_valid = 1'b0;
      end
      begin
        rx_byte(d, s1); check("burst_rx0", 32'(d), 32'hA5);
        rx_byte(d, s2); check("burst_rx1", 32'(d), 32'h3C);
        rx_byte(d, s3); check("burst_rx2", 32'(d), 32'hFF);
        check("burst_gap01", 32'(s2 - s1), 32'd100);
        check("burst_gap12", 32'(s3 - s2), 32'd100);
      end
    join
    wait_idle();

    // Ten bytes against an 8-deep FIFO: back-pressure, in-order delivery
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          tx_data = 8'(8'h30 + i);
          tx_valid = 1'b1;
          n = 0;
          do begin
            acc = tx_ready;
            step();
            n++;
            if (tx_ready === 1'b0) begin
              saw_full = 1'b1;
              check("full_level", 32'(fifo_level), 32'd8);
            end
          end while (!acc && n < 3000);
          check("push_timeout", 32'(acc), 32'd1);
        end
        tx_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          rx_byte(d, s1);
          check($sformatf("ten_rx%0d", i), 32'(d), 32'(8'h30 + i));
        end
      end
    join
    check("ten_saw_full", 32'(saw_full), 32'd1);
    wait_idle();

    // Parity even + 2 stop bits, and odd parity + 1 stop bit, byte 0x07
    b = 8'h07;
    p_data = b;
    pe_valid = 1'b1;
    po_valid = 1'b1;
    step();
    pe_valid = 1'b0;
    po_valid = 1'b0;
    check("par_pe_level", 32'(pe_level), 32'd1);
    check("par_po_level", 32'(po_level), 32'd1);
    for (int c = 1; c <= 122; c++) begin
      step();
      exp_pe = (c >= 2 && c <= 11) ? 1'b0 : (c >= 12 && c <= 91) ? b[(c - 12) / 10] :
               (c >= 92 && c <= 101) ? 1'b1 : 1'b1;
      exp_po = (c >= 2 && c <= 11) ? 1'b0 : (c >= 12 && c <= 91) ? b[(c - 12) / 10] :
               (c >= 92 && c <= 101) ? 1'b0 : 1'b1;
      check($sformatf("pe_txd@%0d", c), 32'(pe_txd), 32'(exp_pe));
      check($sformatf("po_txd@%0d", c), 32'(po_txd), 32'(exp_po));
      check($sformatf("pe_busy@%0d", c), 32'(pe_busy), (c <= 121) ? 32'd1 : 32'd0);
      check($sformatf("po_busy@%0d", c), 32'(po_busy), (c <= 111) ? 32'd1 : 32'd0);
    end
    repeat (5) step();

    // Reset at cycle 45 of a 0x00 frame with 3 bytes queued
    tx_valid = 1'b1;
    tx_data = 8'h00; step();
    tx_data = 8'h11; step();
    tx_data = 8'h22; step();
    tx_data = 8'h33; step();
    tx_valid = 1'b0;
    check("rst_mid_queued", 32'(fifo_level), 32'd3);
    repeat (43) step();
    check("rst_mid_pre_txd", 32'(uart_txd), 32'd0);
    rst = 1'b1;
    step();
    check("rst_mid_txd", 32'(uart_txd), 32'd1);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 300; c++) begin
      step();
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 4'd0) quiet = 1'b0;
    end
    check("rst_mid_quiet", 32'(quiet), 32'd1);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    rx_byte(d, s1);
    check("rst_mid_new_byte", 32'(d), 32'h5A);
    wait_idle();

    // Simultaneous push and pop at level 4
    fork
      begin
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
          tx_data = 8'(8'hC1 + i);
          step();
        end
        tx_valid = 1'b0;
        check("pp_level_fill", 32'(fifo_level), 32'd4);
        repeat (96) step();
        check("pp_level_before", 32'(fifo_level), 32'd4);
        tx_data = 8'hC6;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("pp_level_after", 32'(fifo_level), 32'd4);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rx_byte(d, s1);
          check($sformatf("pp_rx%0d", i), 32'(d), 32'(8'hC1 + i));
        end
      end
    join
    wait_idle();
    check("final_level", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
